// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pipeline skid stage family.
// Holds the skid FSM state encoding used by pipe_stage_skid.
package pipe_pkg;

  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_CTRL_W = 8;
  localparam int PIPE_CNT_W  = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter with synchronous clear (clear wins over increment).
// Count updates one cycle after inc/clr; no backpressure, always accepts events.
module pipe_sat_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = PIPE_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry skid pipeline register: 1-cycle latency, full throughput, FIFO order.
// in_ready comes only from registered state, so out_ready never reaches in_ready combinationally.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int CNT_W  = PIPE_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              clr_stats,
  output logic [CNT_W-1:0]  stall_cnt
);

  skid_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_dat_q, main_dat_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_dat_q, skid_dat_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              rdy_en_q, rdy_en_d;
  logic              accept;
  logic              deliver;
  logic              stall_inc;

  // rdy_en_q keeps in_ready low during reset and until the first edge after release
  assign in_ready  = rdy_en_q && (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_dat_q;
  assign out_ctrl  = out_valid ? main_ctrl_q : '0;
  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid && out_ready;
  assign stall_inc = out_valid && !out_ready;

  always_comb begin
    state_d     = state_q;
    main_dat_d  = main_dat_q;
    main_ctrl_d = main_ctrl_q;
    skid_dat_d  = skid_dat_q;
    skid_ctrl_d = skid_ctrl_q;
    rdy_en_d    = 1'b1;

    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_dat_d  = in_data;
            main_ctrl_d = in_ctrl;
            state_d     = HALF;
          end
        end
        HALF: begin
          if (accept && !deliver) begin
            skid_dat_d  = in_data;
            skid_ctrl_d = in_ctrl;
            state_d     = FULL;
          end else if (accept && deliver) begin
            main_dat_d  = in_data;
            main_ctrl_d = in_ctrl;
          end else if (deliver) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (deliver) begin
            main_dat_d  = skid_dat_q;
            main_ctrl_d = skid_ctrl_q;
            state_d     = HALF;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= EMPTY;
      main_dat_q  <= '0;
      main_ctrl_q <= '0;
      skid_dat_q  <= '0;
      skid_ctrl_q <= '0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_dat_q  <= main_dat_d;
      main_ctrl_q <= main_ctrl_d;
      skid_dat_q  <= skid_dat_d;
      skid_ctrl_q <= skid_ctrl_d;
      rdy_en_q    <= rdy_en_d;
    end
  end

  pipe_sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (stall_inc),
    .clr  (clr_stats),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid with a queue-based reference model.
module tb_pipe_stage_skid;

  localparam int DW = 32;
  localparam int CW = 8;
  localparam int NW = 4;
  localparam int SAT = (1 << NW) - 1;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          flush;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic          clr_stats;
  logic [NW-1:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ctrl(out_ctrl), .clr_stats(clr_stats), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of held beats, capacity two.
  beat_t m_q[$];
  bit    m_rdy_en;
  int    m_stall;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_rdy_en = 1'b0;
      m_stall  = 0;
    end else begin
      bit acc, dlv, stl;
      acc = in_valid && m_rdy_en && (m_q.size() < 2);
      dlv = (m_q.size() > 0) && out_ready;
      stl = (m_q.size() > 0) && !out_ready;
      if (clr_stats) m_stall = 0;
      else if (stl && m_stall < SAT) m_stall++;
      if (flush) begin
        m_q.delete();
      end else begin
        if (dlv) void'(m_q.pop_front());
        if (acc) m_q.push_back({in_data, in_ctrl});
      end
      m_rdy_en = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_ctrl", out_ctrl, 0);
      chk("rst_stall", stall_cnt, 0);
    end else begin
      chk("m_in_ready", in_ready, m_rdy_en && (m_q.size() < 2));
      chk("m_out_valid", out_valid, m_q.size() > 0);
      chk("m_out_ctrl", out_ctrl, (m_q.size() > 0) ? m_q[0].c : 8'h00);
      chk("m_stall", stall_cnt, m_stall);
      if (m_q.size() > 0) chk("m_out_data", out_data, m_q[0].d);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c);
    in_valid = v;
    in_data  = d;
    in_ctrl  = c;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
    flush = 1'b0; out_ready = 1'b0; clr_stats = 1'b0;
    #12;
    chk("lit_rst_in_ready", in_ready, 0);
    chk("lit_rst_out_ctrl", out_ctrl, 0);
    reset = 1'b1;
    chk("lit_in_ready_before_edge", in_ready, 0);
    step();
    chk("lit_in_ready_after_release", in_ready, 1);

    // Streaming at full rate
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      offer(1'b1, 32'hA0 + i, 8'(i + 1));
      step();
      chk("lit_stream_valid", out_valid, 1);
      chk("lit_stream_data", out_data, 32'hA0 + i);
      chk("lit_stream_in_ready", in_ready, 1);
    end
    offer(1'b0, '0, '0);
    step();
    chk("lit_stream_drained", out_valid, 0);

    // Back-pressure: three offers, two accepted
    out_ready = 1'b0;
    offer(1'b1, 32'hB0, 8'h11); step();
    chk("lit_bp_stall0", stall_cnt, 0);
    offer(1'b1, 32'hB1, 8'h12); step();
    chk("lit_bp_in_ready_low", in_ready, 0);
    chk("lit_bp_stall1", stall_cnt, 1);
    offer(1'b1, 32'hB2, 8'h13); step();
    chk("lit_bp_stall2", stall_cnt, 2);
    offer(1'b0, '0, '0); step();
    chk("lit_bp_stall3", stall_cnt, 3);
    chk("lit_bp_head", out_data, 32'hB0);
    out_ready = 1'b1; step();
    chk("lit_bp_second", out_data, 32'hB1);
    chk("lit_bp_second_v", out_valid, 1);
    step();
    chk("lit_bp_done", out_valid, 0);
    chk("lit_bp_stall_hold", stall_cnt, 3);
    clr_stats = 1'b1; step(); clr_stats = 1'b0;
    chk("lit_clr", stall_cnt, 0);

    // Flush while FULL, side-effect control must vanish
    out_ready = 1'b0;
    offer(1'b1, 32'hC0, 8'h81); step();
    offer(1'b1, 32'hC1, 8'h81); step();
    offer(1'b0, '0, '0);
    chk("lit_full_ctrl", out_ctrl, 8'h81);
    chk("lit_full_in_ready", in_ready, 0);
    flush = 1'b1; step(); flush = 1'b0;
    chk("lit_flush_valid", out_valid, 0);
    chk("lit_flush_ctrl", out_ctrl, 8'h00);
    chk("lit_flush_in_ready", in_ready, 1);
    out_ready = 1'b1; step(); step();
    chk("lit_flush_no_ghost", out_valid, 0);

    // Flush while HALF drops the beat offered in the same cycle
    out_ready = 1'b0;
    offer(1'b1, 32'hD0, 8'h21); step();
    offer(1'b1, 32'hD1, 8'h22); flush = 1'b1;
    chk("lit_flush_half_in_ready", in_ready, 1);
    step(); flush = 1'b0; offer(1'b0, '0, '0);
    chk("lit_flush_half_valid", out_valid, 0);
    out_ready = 1'b1; step();
    chk("lit_flush_half_no_ghost", out_valid, 0);

    // Saturation of the stall counter
    clr_stats = 1'b1; step(); clr_stats = 1'b0;
    out_ready = 1'b0;
    offer(1'b1, 32'hE0, 8'h31); step();
    offer(1'b0, '0, '0);
    for (int i = 0; i < 20; i++) step();
    chk("lit_sat", stall_cnt, 4'hF);
    clr_stats = 1'b1; step(); clr_stats = 1'b0;
    chk("lit_clr_over_inc", stall_cnt, 0);
    step();
    chk("lit_after_clr", stall_cnt, 1);
    out_ready = 1'b1; step();
    chk("lit_sat_drain", out_valid, 0);

    // Asynchronous reset while HALF
    out_ready = 1'b0;
    offer(1'b1, 32'hF0, 8'h41); step();
    offer(1'b0, '0, '0);
    chk("lit_half_valid", out_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("lit_arst_valid", out_valid, 0);
    chk("lit_arst_data", out_data, 0);
    chk("lit_arst_ctrl", out_ctrl, 0);
    chk("lit_arst_stall", stall_cnt, 0);
    chk("lit_arst_in_ready", in_ready, 0);
    step();
    reset = 1'b1;
    out_ready = 1'b1;
    step();
    chk("lit_rel_in_ready", in_ready, 1);
    chk("lit_rel_no_stale", out_valid, 0);
    step(); step();
    chk("lit_rel_no_stale2", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL provide parameter DATA_W, default 32: payload width (rd_data, mem address, store data, instruction, rd_addr packed by the instantiating stage).
REQ-002 SHALL provide parameter CTRL_W, default 8: side-effect control width (rd_we, mmr_we, mem_flag and similar).
REQ-003 SHALL provide parameter CNT_W, default 16: stall-counter width.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates occur on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1: the upstream stage offers a beat.
REQ-007 SHALL have port in_ready, output, 1: this block can accept a beat.
REQ-008 SHALL have ports in_data (input, DATA_W) and in_ctrl (input, CTRL_W): the upstream payload and control.
REQ-009 SHALL have port flush, input, 1: synchronous kill of all held beats.
REQ-010 SHALL have port out_valid, output, 1: a beat is presented to the downstream stage.
REQ-011 SHALL have port out_ready, input, 1: the downstream stage accepts the presented beat.
REQ-012 SHALL have ports out_data (output, DATA_W) and out_ctrl (output, CTRL_W): the presented beat.
REQ-013 SHALL have port clr_stats, input, 1: synchronous clear of stall_cnt.
REQ-014 SHALL have port stall_cnt, output, CNT_W: saturating count of back-pressure cycles.

Function
REQ-015 SHALL treat a beat as accepted when in_valid && in_ready, and as delivered when out_valid && out_ready.
REQ-016 SHALL implement a two-entry skid buffer with a main register and a skid register, under FSM states EMPTY, HALF and FULL.
REQ-017 SHALL make in_ready = (state != FULL), driven from registered state only, with no combinational path from out_ready to in_ready.
REQ-018 SHALL assert out_valid in HALF and FULL only, and drive out_data and out_ctrl from the main register.
REQ-019 SHALL make out_ctrl = 0 whenever out_valid = 0, so that no side effect leaks from a bubble.
REQ-020 SHALL follow these state transitions:
- EMPTY: accept -> HALF (main register loaded).
- HALF: accept without deliver -> FULL (skid register loaded); deliver without accept -> EMPTY; accept and deliver -> HALF (main register loaded with the new beat).
- FULL: deliver -> HALF (skid moves to main); no accept is possible.
REQ-021 SHALL have a latency of 1 cycle from acceptance to out_valid when EMPTY.
REQ-022 SHALL sustain 1 beat per cycle throughput while out_ready = 1.
REQ-023 SHALL preserve strict FIFO order, with no beat duplicated or dropped except by flush.
REQ-024 SHALL give flush the highest priority:
- Next state is EMPTY.
- A beat offered in the same cycle is dropped.
- A beat delivered in the same cycle counts as delivered.
REQ-025 SHALL assert in_ready during a flush cycle (unless FULL) and leave it asserted afterwards.
REQ-026 SHALL increment stall_cnt each cycle that out_valid && !out_ready, saturating at all-ones without wrap.
REQ-027 SHALL give clr_stats priority over increment in the same cycle (result 0); flush SHALL NOT clear stall_cnt.

Reset
REQ-028 SHALL, while reset = 0, force: state EMPTY, out_valid 0, out_ctrl 0, out_data 0, the skid register 0, and stall_cnt 0.
REQ-029 SHALL hold in_ready at 0 while reset is asserted and make it 1 on the first clock edge after release.
REQ-030 SHALL, on reset mid-operation, discard all held beats immediately, with no delivery after release.

Structure
REQ-031 SHALL take the FSM state enum (EMPTY/HALF/FULL) and the default DATA_W/CTRL_W/CNT_W from shared package pipe_pkg.
REQ-032 SHALL implement stall_cnt in sub-module pipe_sat_counter (parameter CNT_W; inputs inc and clr; output count).
REQ-033 SHALL place no logic between stages beyond this block; the instantiating stage packs and unpacks the payload fields.

Verification
REQ-034 Streaming: out_ready = 1; beats 0xA0..0xA7 offered on consecutive cycles -> out_data 0xA0..0xA7 on cycles 1..8, in_ready = 1 throughout.
REQ-035 Back-pressure: out_ready = 0 and three beats offered -> two accepted, in_ready = 0 from the third cycle, stall_cnt increments each stalled cycle; on out_ready = 1 the two beats are delivered in order.
REQ-036 Flush while FULL with ctrl = 0x81 -> next cycle out_valid = 0, out_ctrl = 0x00, in_ready = 1; the held beats never appear.
REQ-037 Saturation: CNT_W = 4, 20 stalled cycles -> stall_cnt = 0xF; clr_stats in the same cycle as a stall -> 0.
REQ-038 Reset asserted while HALF -> outputs 0 asynchronously; after release in_ready = 1 and no stale beat is delivered.
